// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM link controller.
// Optional feature macro used by the top level: LOOPBACK_CHECK_EN.
package tdm_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  // Frame FSM states; exposed as the internal signal 'state' in the top.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_link_ctrl_slot_timer.sv
// Dwell counter for one channel slot. Counts 0..DWELL-1 while enabled.
// 'tick' marks the terminal count, which is the slot's sampling edge.
module slot_timer
  import tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & (cnt == TERM);

  // Count within a slot; restart on a new frame or at each slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_link_ctrl.sv
// Frame controller for the 4-channel mux/demux serial link.
// Accepts a word, drives it to the mux, walks the shared select through
// all channels (DWELL cycles each), samples the line per slot and
// presents the reassembled word with a one-cycle out_valid pulse.
// Handshake: a word is accepted on a rising edge where in_valid and
// in_ready are both high; in_valid while busy is ignored, and out_valid
// has no backpressure.
// Optional macro LOOPBACK_CHECK_EN adds 'err', a loopback mismatch flag.
module tdm_link_ctrl
  import tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NCH-1:0]   mux_d,
  output logic [SEL_W-1:0] sel,
  input  logic             link_in,
  output logic [NCH-1:0]   out_data,
  output logic             out_valid,
  output logic             busy
`ifdef LOOPBACK_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  state_t           state;
  logic [NCH-2:0]   shadow;
  logic             accept;
  logic             tick;
  logic             scanning;
  logic [NCH-1:0]   frame_word;

  assign in_ready   = (state == IDLE);
  assign busy       = ~in_ready;
  assign accept     = in_valid & in_ready;
  assign scanning   = (state == SCAN);
  // Word as it will stand once the last slot's sample is taken.
  assign frame_word = {link_in, shadow};

  slot_timer #(
    .DWELL (DWELL)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (scanning),
    .tick  (tick)
  );

  // Frame FSM with registered select, mux word, shadow and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mux_d     <= '0;
      sel       <= '0;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          sel <= '0;
          if (accept) begin
            mux_d <= in_data;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (tick) begin
            if (sel == SEL_LAST) begin
              // Last slot: the sample goes straight into the result.
              out_data  <= frame_word;
              out_valid <= 1'b1;
`ifdef LOOPBACK_CHECK_EN
              err       <= (frame_word != mux_d);
`endif
              sel       <= '0;
              state     <= IDLE;
            end else begin
              shadow[sel] <= link_in;
              sel         <= sel + SEL_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tdm_link_ctrl.md
# tdm_link_ctrl

Sequential frame controller for the 4-channel mux/demux serial link. Accepts a 4-bit word from upstream with a valid/ready handshake and drives it onto the mux data inputs. Steps the shared 2-bit select through all four channels, with each channel held for a fixed dwell time. Samples the serial line on each slot, then presents the reassembled word downstream with a one-cycle valid pulse; it is the block that generates S for both mux and demux and consumes the link.

## Interface
- `DWELL`, default 4: cycles each channel slot is held; legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_data`  in  4  word to transmit; sampled on accept edge.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  high when block can accept; accept = `in_valid & in_ready` at rising edge.
- `mux_d`  out  4  registered word driven to mux D inputs.
- `sel`  out  2  registered channel select to mux S and demux S.
- `link_in`  in  1  serial line (mux output), sampled per slot.
- `out_data`  out  4  reassembled word; bit k = line value sampled in slot k.
- `out_valid`  out  1  one-cycle pulse; `out_data` is new.
- `busy`  out  1  frame in progress; equals `~in_ready`.
- `err`  out  1  present only with `LOOPBACK_CHECK_EN` (see Configuration).

## Operation
- States: IDLE, SCAN.
- Reset, asynchronous:
  - State goes to IDLE.
  - `mux_d`, `sel`, `out_data`, shadow register and dwell counter clear to 0.
  - `out_valid` and `err` clear to 0.
  - `in_ready` is decoded from the state, so it reads 1 once the state is IDLE.
- IDLE:
  - `in_ready`=1 and `sel` holds 0.
  - `mux_d` holds the last transmitted word.
  - On accept: `mux_d`<=`in_data`, `sel`<=0, dwell counter<=0, state moves to SCAN.
- SCAN:
  - `in_ready`=0. The dwell counter counts 0..DWELL-1.
  - On the counter's terminal edge, `link_in` is written into shadow bit `sel` and the counter clears.
  - If `sel`≠3, `sel` increments.
  - If `sel`=3, the following happen on the same edge:
    - `out_data` loads {link_in, shadow[2:0]}.
    - `out_valid` pulses.
    - `sel` returns to 0.
    - State moves to IDLE.
- Bit mapping: bit k of `out_data` equals the line value sampled in slot k. For a correct link this equals `mux_d[k]`.
- `in_valid` while busy is ignored: no capture and no side effect. Upstream must hold the word until it is accepted.
- `out_valid` has no backpressure. Downstream must take the word in the pulse cycle.
- `out_data` holds its value until the next frame completes.

## Timing
- Accept edge E0. Slot k occupies the cycles after edges E0+k·DWELL through E0+(k+1)·DWELL.
- Sample for slot k is taken at edge E0+(k+1)·DWELL.
- Latency from accept edge to `out_valid` high: 4·DWELL cycles (16 at default).
- The mux is combinational, so `link_in` is stable within the slot's first cycle. DWELL=1 is therefore legal.
- Back-to-back frames: `in_ready` is 1 in the `out_valid` cycle, so the next accept can occur on that edge.
  - Sustained throughput is one word per 4·DWELL cycles plus one idle-accept cycle.
- Reset asserted mid-frame:
  - The frame is aborted and no `out_valid` is produced.
  - `out_data` reads 0 after reset.

## Configuration
- `LOOPBACK_CHECK_EN` defined:
  - Adds output `err`.
  - `err` pulses together with `out_valid` when the reassembled word ≠ `mux_d`; otherwise it is 0.
- `LOOPBACK_CHECK_EN` undefined:
  - Port `err` and the comparator are absent.
  - All other behaviour is identical.

## Structure
- Package `tdm_pkg` holds:
  - `NCH`=4 and `SEL_W`=2.
  - State enum {IDLE, SCAN}.
  - Dwell counter width: 4 bits.
- Sub-module `slot_timer`:
  - Dwell counter, parameterised by `DWELL`.
  - Inputs `clk`, `rst_n`, `clr`, `en`; output `tick` high on the terminal count.
- Top level: FSM, select register, shadow register, output register, optional comparator.

## Test plan
All scenarios run with the real mux/demux instances on the link.
- Reset: hold `rst_n`=0, then release -> `sel`=0, `mux_d`=0, `out_data`=0, `out_valid`=0, `in_ready`=1.
- Single frame, DWELL=4, `in_data`=0110 -> `sel` steps 0,1,2,3 for 4 cycles each; `out_data`=0110 with `out_valid` 16 cycles after accept; then `sel`=0.
- Back-to-back 1010 then 0101, `in_valid` held high -> second word accepted in the first `out_valid` cycle; pulses at +16 (1010) and +33 (0101).
- `in_valid` pulsed with 1111 at cycle 5 of a 0110 frame -> not captured; result 0110; `in_ready`=0 throughout.
- Async reset at cycle 6 of a frame -> outputs cleared immediately; no `out_valid`; next frame with DWELL=1 yields `out_data`=1001 after 4 cycles.
- `LOOPBACK_CHECK_EN`: `link_in` forced 0, `in_data`=1111 -> `out_data`=0000 and `err`=1 coincident with `out_valid`; with link unforced, `err`=0.
